rggen_apb_initiator: RTL

APB initiator that turns a simple command/response handshake into APB transfers. It drives the `apb_if` of a generated register block, or any APB completer, from firmware-less logic such as test sequencers, DMA-style configuration loaders or bus bridges. It issues one transfer at a time. Each result is held in a one-entry response buffer with back-pressure, and an optional timeout guards against a completer that never responds.

---
 rtl/rggen_apb_initiator.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rggen_apb_initiator.sv
// APB initiator: command/response handshake in, one APB transfer at a time out, result held in a 1-entry buffer.
// Optional ACCESS-phase timeout is compiled in with `define RGGEN_APB_INITIATOR_TIMEOUT_EN.
module rggen_apb_initiator #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [DATA_WIDTH-1:0]    i_cmd_write_data,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [DATA_WIDTH-1:0]    o_rsp_read_data,
  output logic [1:0]               o_rsp_status,
  output logic                     o_psel,
  output logic                     o_penable,
  output logic                     o_pwrite,
  output logic [ADDRESS_WIDTH-1:0] o_paddr,
  output logic [DATA_WIDTH-1:0]    o_pwdata,
  input  logic                     i_pready,
  input  logic                     i_pslverr,
  input  logic [DATA_WIDTH-1:0]    i_prdata
);
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETUP  = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;

  logic [1:0]               state_q, state_d;
  logic                     psel_q, psel_d;
  logic                     penable_q, penable_d;
  logic                     pwrite_q, pwrite_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]    pwdata_q, pwdata_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic [1:0]               rsp_status_q, rsp_status_d;
  logic                     timeout_hit;

  // Held low while reset is asserted so nothing is offered to the command side.
  assign o_cmd_ready = rst_n && (state_q == IDLE) && (!rsp_valid_q || i_rsp_ready);

  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    if (rsp_valid_q && i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = i_cmd_write;
          paddr_d   = i_cmd_address;
          pwdata_d  = i_cmd_write_data;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // A pready in the terminal-count cycle takes priority over the timeout.
        if (i_pready || timeout_hit) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          if (i_pready) begin
            rsp_status_d = {i_pslverr, 1'b0};
            rsp_data_d   = pwrite_q ? '0 : i_prdata;
          end else begin
            rsp_status_d = 2'b11;
            rsp_data_d   = '0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

`ifdef RGGEN_APB_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt_q;

  assign timeout_hit = (state_q == ACCESS) && !i_pready && (to_cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      to_cnt_q <= '0;
    end else if ((state_q == ACCESS) && !i_pready) begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end
`else
  // Legal TIMEOUT_CYCLES is >= 1, so ACCESS waits for pready indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES < 1);
`endif

  assign o_psel          = psel_q;
  assign o_penable       = penable_q;
  assign o_pwrite        = pwrite_q;
  assign o_paddr         = paddr_q;
  assign o_pwdata        = pwdata_q;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_read_data = rsp_data_q;
  assign o_rsp_status    = rsp_status_q;

endmodule
